// File: rtl/sensor_cond.sv
// Crank-cadence counter and torque low-pass filter for the pedal-assist drive path.
// Latency: cadence_edge is registered 3 clocks after the raw rise is sampled; cadence updates on the window terminal cycle.
// Backpressure: none; torque is consumed every cycle and all outputs are free-running levels or pulses.
module sensor_cond #(
    parameter int WIN_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] torque,
    input  logic        cadence_raw,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling,
    output logic        cadence_edge
);

    // Two-flop synchronizer followed by the edge-detect flop.
    logic sync1;
    logic sync2;
    logic sync3;
    // in_vld marks that sync1 holds a genuine post-reset sample rather than its reset value.
    logic in_vld;
    // armed goes high once the synchronized input has been seen low after reset, so a
    // level held high through reset is never mistaken for a fresh crank edge.
    logic armed;

    // Window timer and per-window edge count.
    logic [WIN_W-1:0] win_cnt;
    logic             win_term;
    logic [4:0]       edge_cnt;
    logic [5:0]       edge_sum;
    logic [4:0]       edge_sat;

    // Torque filter state.
    logic [16:0] accum;
    logic [16:0] accum_upd;
    logic        np_next;
    logic        seed;

    // Synchronize the crank pulse and register a single-cycle qualified rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            in_vld       <= 1'b0;
            armed        <= 1'b0;
            cadence_edge <= 1'b0;
        end else begin
            sync1        <= cadence_raw;
            sync2        <= sync1;
            sync3        <= sync2;
            in_vld       <= 1'b1;
            if (in_vld && !sync1) begin
                armed <= 1'b1;
            end
            cadence_edge <= sync2 & ~sync3 & armed;
        end
    end

    assign win_term = &win_cnt;

    // Free-running cadence window timer; wraps naturally after the all-ones terminal cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    // Edge count including the current cycle's edge, clamped so the counter never wraps.
    always_comb begin
        edge_sum = {1'b0, edge_cnt} + {5'b0, cadence_edge};
        edge_sat = edge_sum[4:0];
        if (edge_sum > 6'd31) begin
            edge_sat = 5'd31;
        end
    end

    // Count edges in the open window; on the terminal cycle latch the total (including a
    // coincident edge) and start the next window from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            cadence  <= '0;
        end else if (win_term) begin
            edge_cnt <= '0;
            cadence  <= edge_sat;
        end else begin
            edge_cnt <= edge_sat;
        end
    end

    assign np_next = (cadence < 5'd2);

    // Registered pedaling flag trails the latched cadence by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            not_pedaling <= 1'b1;
        end else begin
            not_pedaling <= np_next;
        end
    end

    // Seed on the cycle pedaling resumes; otherwise a 31/32 average step per crank edge.
    // accum - accum/32 + torque stays below 4095*32, so 17 bits never overflow.
    always_comb begin
        seed      = not_pedaling & ~np_next;
        accum_upd = accum - {5'b0, accum[16:5]} + {5'b0, torque};
    end

    // Filter accumulator: seed has priority; holds while not pedaling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accum <= '0;
        end else if (seed) begin
            accum <= {torque, 5'b0};
        end else if (cadence_edge && !not_pedaling) begin
            accum <= accum_upd;
        end
    end

    assign avg_torque = accum[16:5];

endmodule

// File: tb/tb_sensor_cond.sv
module tb_sensor_cond;
    localparam int WIN_W = 8;
    localparam int WIN   = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] torque;
    logic        cadence_raw;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic        cadence_edge;

    sensor_cond #(.WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .torque       (torque),
        .cadence_raw  (cadence_raw),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .cadence_edge (cadence_edge)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers, cycle-level view of the rules).
    int m_pos;        // clocks elapsed in the current window
    int m_cnt;        // edges seen so far in the open window
    int m_cad;        // latched cadence
    int m_acc;        // filter accumulator (value x32)
    bit m_np;
    bit m_ce;
    bit m_p0, m_p1;   // detected edges still travelling to the output
    bit m_prev_raw;
    bit m_prev_vld;
    int edges_seen;
    int dut_edges;
    bit rand_tq;
    int prev_avg;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit ce_old;
        bit new_np;
        int nc;
        if (!rst_n) begin
            m_pos = 0; m_cnt = 0; m_cad = 0; m_acc = 0;
            m_np = 1'b1; m_ce = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0;
            m_prev_raw = 1'b0; m_prev_vld = 1'b0;
        end else begin
            ce_old = m_ce;
            nc = m_cnt + (ce_old ? 1 : 0);
            if (nc > 31) nc = 31;
            new_np = (m_cad < 2);
            if (m_np && !new_np)
                m_acc = int'(torque) * 32;
            else if (ce_old && !m_np)
                m_acc = m_acc - m_acc / 32 + int'(torque);
            if (m_pos == WIN - 1) begin
                m_cad = nc;
                m_cnt = 0;
            end else begin
                m_cnt = nc;
            end
            m_np = new_np;
            // a rise counts only between two post-reset samples: low then high
            m_ce = m_p1;
            m_p1 = m_p0;
            m_p0 = m_prev_vld && !m_prev_raw && cadence_raw;
            m_prev_raw = cadence_raw;
            m_prev_vld = 1'b1;
            m_pos = (m_pos + 1) % WIN;
            if (m_ce) edges_seen++;
        end
    endtask

    task automatic tick();
        if (rand_tq) torque = 12'($urandom_range(0, 4095));
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (cadence_edge) dut_edges++;
        check("avg_torque", avg_torque, m_acc / 32);
        check("cadence", cadence, m_cad);
        check("not_pedaling", not_pedaling, m_np);
        check("cadence_edge", cadence_edge, m_ce);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            cadence_raw = 1'b1; ticks(hi);
            cadence_raw = 1'b0; ticks(lo);
        end
    endtask

    // Let in-flight edges settle, then advance to just after the next terminal cycle.
    task automatic win_start();
        ticks(4);
        for (int i = 0; i < WIN && m_pos != 0; i++) tick();
    endtask

    task automatic mono_tick();
        tick();
        check("avg_monotonic", (int'(avg_torque) >= prev_avg) ? 1 : 0, 1);
        check("avg_not_above_target", (int'(avg_torque) <= 'h800) ? 1 : 0, 1);
        prev_avg = avg_torque;
    endtask

    initial begin
        rst_n = 1'b0; cadence_raw = 1'b0; torque = 12'd0; rand_tq = 1'b0;
        edges_seen = 0; dut_edges = 0; prev_avg = 0;
        m_pos = 0; m_cnt = 0; m_cad = 0; m_acc = 0; m_np = 1'b1; m_ce = 1'b0;
        m_p0 = 1'b0; m_p1 = 1'b0; m_prev_raw = 1'b0; m_prev_vld = 1'b0;
        ticks(3);
        check("rst_cadence", cadence, 0);
        check("rst_not_pedaling", not_pedaling, 1);
        check("rst_avg", avg_torque, 0);
        check("rst_edge", cadence_edge, 0);

        // Idle for three windows with random torque: nothing may move.
        rst_n = 1'b1; rand_tq = 1'b1;
        ticks(3 * WIN + 10);
        check("idle_cadence", cadence, 0);
        check("idle_not_pedaling", not_pedaling, 1);
        check("idle_avg", avg_torque, 0);

        // Ten pulses in one window, then seed on pedaling resume.
        win_start();
        pulses(10, 4, 20);
        win_start();
        check("ten_cadence", cadence, 10);
        check("ten_np_before", not_pedaling, 1);
        rand_tq = 1'b0; torque = 12'h5A3;
        tick();
        check("ten_np_fall", not_pedaling, 0);
        check("ten_seed", avg_torque, 'h5A3);
        rand_tq = 1'b1;

        // Forty pulses saturate, then an empty window stops pedaling.
        pulses(40, 2, 2);
        win_start();
        check("sat_cadence", cadence, 31);
        win_start();
        check("empty_cadence", cadence, 0);
        tick();
        check("empty_np", not_pedaling, 1);

        // Seed at 0x380, then hold 0x800 and pedal continuously.
        rand_tq = 1'b0; torque = 12'h380;
        pulses(20, 2, 2);
        win_start();
        check("seed_cadence", cadence, 20);
        tick();
        check("seed_avg", avg_torque, 'h380);
        torque = 12'h800; edges_seen = 0; prev_avg = avg_torque;
        for (int i = 0; i < 600 && edges_seen < 400; i++) begin
            cadence_raw = 1'b1; mono_tick(); mono_tick();
            cadence_raw = 1'b0; mono_tick(); mono_tick();
        end
        check("conv_edges", (edges_seen >= 400) ? 1 : 0, 1);
        check("conv_avg", (avg_torque >= 12'h7FF && avg_torque <= 12'h800) ? 1 : 0, 1);

        // Edge landing exactly on the terminal cycle after five prior edges.
        rand_tq = 1'b1;
        win_start();
        pulses(5, 4, 20);
        for (int i = 0; i < WIN && m_pos != 252; i++) tick();
        cadence_raw = 1'b1;
        ticks(3);
        check("term_pos", m_pos, 255);
        check("term_edge", cadence_edge, 1);
        tick();
        check("term_cadence", cadence, 6);
        cadence_raw = 1'b0;
        win_start();
        check("term_next", cadence, 0);

        // One-cycle reset mid-window with the crank input held high.
        win_start();
        pulses(2, 4, 20);
        cadence_raw = 1'b1;
        ticks(6);
        rst_n = 1'b0;
        tick();
        check("mid_rst_cadence", cadence, 0);
        check("mid_rst_np", not_pedaling, 1);
        check("mid_rst_edge", cadence_edge, 0);
        check("mid_rst_avg", avg_torque, 0);
        rst_n = 1'b1; dut_edges = 0;
        ticks(10);
        check("no_spurious_edge", dut_edges, 0);
        cadence_raw = 1'b0;
        ticks(4);
        pulses(3, 4, 20);
        ticks(WIN - 1 - 86);
        check("restart_pre_term", cadence, 0);
        tick();
        check("restart_cadence", cadence, 3);
        ticks(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
